fadc_seq_ctrl: RTL

Conversion sequencer for the flash ADC macro. Drives the precharge, sample, compare and latch phase strobes of the full-custom comparator bank, and captures the thermometer code. The code is converted to binary by counting ones (popcount), which tolerates bubbles. The block averages 2^A conversions and hands the result to the digital side over a valid/ready handshake. Timing and averaging configuration comes from the scan chain and is shadowed at the start of each batch.

---
 rtl/fadc_seq_ctrl_if.sv | 24 ++
 rtl/fadc_seq_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fadc_seq_ctrl_if.sv
// Result handshake between the flash ADC sequencer and the digital consumer.
// The producer holds dout/bubble_err/result_valid stable until result_ready is seen.
interface fadc_seq_ctrl_if #(
  parameter int NBITS = 4
);
  logic             result_valid;
  logic             result_ready;
  logic [NBITS-1:0] dout;
  logic             bubble_err;

  modport master (
    output result_valid,
    output dout,
    output bubble_err,
    input  result_ready
  );

  modport slave (
    input  result_valid,
    input  dout,
    input  bubble_err,
    output result_ready
  );
endinterface

// File: rtl/fadc_seq_ctrl.sv
// Flash ADC conversion sequencer: phase strobes, popcount of thermometer code, 2^A averaging.
// Latency 2^A*(P'+S'+3) cycles from start; result held in DONE until result_ready.
module fadc_seq_ctrl #(
  parameter int NBITS = 4,
  parameter int AVGW  = 3,
  localparam int TW   = (1 << NBITS) - 1,
  localparam int CW   = (1 << AVGW) - 1,
  localparam int AW   = NBITS + CW
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [3:0]      cfg_pre_cyc,
  input  logic [7:0]      cfg_smp_cyc,
  input  logic [AVGW-1:0] cfg_avg_log2,
  input  logic [TW-1:0]   fc_therm,
  output logic            fc_precharge,
  output logic            fc_sample,
  output logic            fc_compare,
  output logic            fc_latch,
  output logic            busy,
  fadc_seq_ctrl_if.master res
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] PRECHARGE = 3'd1;
  localparam logic [2:0] SAMPLE    = 3'd2;
  localparam logic [2:0] COMPARE   = 3'd3;
  localparam logic [2:0] LATCH     = 3'd4;
  localparam logic [2:0] ACCUM     = 3'd5;
  localparam logic [2:0] DONE      = 3'd6;

  localparam logic [TW-1:0] ONE_T = 1;
  localparam logic [CW-1:0] ONE_C = 1;

  logic [2:0]       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [CW-1:0]    conv_q, conv_d;
  logic [3:0]       pre_q, pre_d;
  logic [7:0]       smp_q, smp_d;
  logic [AVGW-1:0]  avg_q, avg_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [TW-1:0]    therm_q, therm_d;
  logic             flag_q, flag_d;
  logic [NBITS-1:0] dout_q, dout_d;
  logic             berr_q, berr_d;
  logic             vld_q, vld_d;
  logic             pre_stb_q, smp_stb_q, cmp_stb_q, lat_stb_q, busy_q;

  logic [NBITS-1:0] pop;
  logic             bubble;
  logic [AW-1:0]    acc_sum;
  logic [CW-1:0]    conv_last;

  // Popcount rather than edge search, so a bubble only costs its own LSB weight.
  always_comb begin
    pop = '0;
    for (int i = 0; i < TW; i++) begin
      pop = pop + {{(NBITS-1){1'b0}}, therm_q[i]};
    end
  end

  // A clean code has all ones packed at the LSB end, so adding one clears them all.
  assign bubble    = |(therm_q & (therm_q + ONE_T));
  assign acc_sum   = acc_q + {{CW{1'b0}}, pop};
  assign conv_last = (ONE_C << avg_q) - ONE_C;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    conv_d  = conv_q;
    pre_d   = pre_q;
    smp_d   = smp_q;
    avg_d   = avg_q;
    acc_d   = acc_q;
    therm_d = therm_q;
    flag_d  = flag_q;
    dout_d  = dout_q;
    berr_d  = berr_q;
    vld_d   = vld_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          pre_d   = (cfg_pre_cyc == 4'd0) ? 4'd1 : cfg_pre_cyc;
          smp_d   = (cfg_smp_cyc == 8'd0) ? 8'd1 : cfg_smp_cyc;
          avg_d   = cfg_avg_log2;
          acc_d   = '0;
          conv_d  = '0;
          flag_d  = 1'b0;
          cnt_d   = {4'd0, pre_d} - 8'd1;
          state_d = PRECHARGE;
        end
      end
      PRECHARGE: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = smp_q - 8'd1;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SAMPLE: begin
        if (cnt_q == 8'd0) begin
          state_d = COMPARE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      COMPARE: state_d = LATCH;
      LATCH: begin
        therm_d = fc_therm;
        state_d = ACCUM;
      end
      ACCUM: begin
        acc_d  = acc_sum;
        flag_d = flag_q | bubble;
        if (conv_q == conv_last) begin
          dout_d  = NBITS'(acc_sum >> avg_q);
          berr_d  = flag_q | bubble;
          vld_d   = 1'b1;
          state_d = DONE;
        end else begin
          conv_d  = conv_q + ONE_C;
          cnt_d   = {4'd0, pre_q} - 8'd1;
          state_d = PRECHARGE;
        end
      end
      DONE: begin
        if (res.result_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes and busy are registered from the next state so they align with it glitch-free.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      conv_q    <= '0;
      pre_q     <= '0;
      smp_q     <= '0;
      avg_q     <= '0;
      acc_q     <= '0;
      therm_q   <= '0;
      flag_q    <= 1'b0;
      dout_q    <= '0;
      berr_q    <= 1'b0;
      vld_q     <= 1'b0;
      pre_stb_q <= 1'b0;
      smp_stb_q <= 1'b0;
      cmp_stb_q <= 1'b0;
      lat_stb_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      conv_q    <= conv_d;
      pre_q     <= pre_d;
      smp_q     <= smp_d;
      avg_q     <= avg_d;
      acc_q     <= acc_d;
      therm_q   <= therm_d;
      flag_q    <= flag_d;
      dout_q    <= dout_d;
      berr_q    <= berr_d;
      vld_q     <= vld_d;
      pre_stb_q <= (state_d == PRECHARGE);
      smp_stb_q <= (state_d == SAMPLE);
      cmp_stb_q <= (state_d == COMPARE);
      lat_stb_q <= (state_d == LATCH);
      busy_q    <= (state_d != IDLE);
    end
  end

  assign fc_precharge     = pre_stb_q;
  assign fc_sample        = smp_stb_q;
  assign fc_compare       = cmp_stb_q;
  assign fc_latch         = lat_stb_q;
  assign busy             = busy_q;
  assign res.result_valid = vld_q;
  assign res.dout         = dout_q;
  assign res.bubble_err   = berr_q;

endmodule
